// File: rtl/fadd_pkg.sv
// fadd_pkg: shared widths, the packed single-precision layout and the normalizer FSM states
package fadd_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] frac;
  } fp32_t;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} norm_state_t;
endpackage

// File: rtl/fp_sub_normalizer_if.sv
// fp_sub_normalizer_if: operand valid/ready input side and result valid/ready output side
interface fp_sub_normalizer_if import fadd_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic [MAN_W+1:0]       m_r;
  logic                   round_in;
  logic [EXP_W-1:0]       exp_in;
  logic                   sign_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;
  logic                   zero;
  logic                   underflow;
  modport master (
    output in_valid, m_r, round_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, result, zero, underflow
  );
  modport slave (
    input  in_valid, m_r, round_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, result, zero, underflow
  );
endinterface

// File: rtl/fp_sub_normalizer.sv
// fp_sub_normalizer: iterative 1-bit/cycle normalize, round-half-up and pack of a subtract result
module fp_sub_normalizer import fadd_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input logic                clk,
  input logic                reset,
  fp_sub_normalizer_if.slave bus
);
  localparam int W = MAN_W + 3;
  norm_state_t          state_q, state_d;
  logic [W-1:0]         w_q, w_d;
  logic [EXP_W-1:0]     e_q, e_d;
  logic                 s_q, s_d;
  logic [EXP_W+MAN_W:0] res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 unf_q, unf_d;
  logic [MAN_W:0]       sum;
  logic [EXP_W:0]       e_inc;
  logic [W-1:0]         w_in;
  assign w_in  = {bus.m_r, bus.round_in};
  assign sum   = {1'b0, w_q[MAN_W+1:2]} + (MAN_W+1)'(w_q[1]);
  assign e_inc = {1'b0, e_q} + (EXP_W+1)'(sum[MAN_W]);
  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      e_q     <= e_d;
      s_q     <= s_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      unf_q   <= unf_d;
    end
  end
  // Next state: accept, shift until the implicit-1 slot is set or the exponent runs out, round, hold
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    e_d     = e_q;
    s_d     = s_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        w_d     = w_in;
        e_d     = bus.exp_in;
        s_d     = bus.sign_in;
        res_d   = '0;
        zero_d  = w_in == '0;
        unf_d   = 1'b0;
        state_d = (w_in == '0) ? DONE : SHIFT;
      end
      SHIFT: if (w_q[W-1]) begin
        state_d = ROUND;
      end else if (e_q == EXP_W'(1)) begin
        res_d   = {s_q, {(EXP_W+MAN_W){1'b0}}};
        unf_d   = 1'b1;
        state_d = DONE;
      end else begin
        w_d = w_q << 1;
        e_d = e_q - EXP_W'(1);
      end
      ROUND: begin
        res_d   = (e_inc[EXP_W] || &e_inc[EXP_W-1:0])
                ? {s_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                : {s_q, e_inc[EXP_W-1:0], sum[MAN_W-1:0]};
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_fp_sub_normalizer.sv
// tb_fp_sub_normalizer: directed table, hold/reset sequences and randomized model comparison
module tb_fp_sub_normalizer;
  import fadd_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  fp_sub_normalizer_if bus ();
  fp_sub_normalizer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [24:0] m;
    logic        r;
    logic [7:0]  e;
    logic        s;
    logic [31:0] res;
    logic        z;
    logic        u;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // Reference: count leading zeros of the 26-bit difference, decide underflow, round the
  // normalized significand as an integer. Latency is the number of clock edges after the
  // accept edge until out_valid is seen (the zero path reaches DONE on the accept edge).
  function automatic void model(input logic [24:0] m, input logic r, input logic [7:0] e,
                                input logic s, output logic [31:0] res, output logic z,
                                output logic u, output int lat);
    logic [25:0] w;
    logic [25:0] wn;
    logic [24:0] sig;
    int k;
    int ee;
    w = {m, r};
    z = 1'b0;
    u = 1'b0;
    if (w == 26'd0) begin
      res = 32'd0;
      z = 1'b1;
      lat = 0;
      return;
    end
    k = 0;
    while (!w[25-k]) k++;
    if (k >= int'(e)) begin
      res = {s, 31'd0};
      u = 1'b1;
      lat = int'(e);
      return;
    end
    wn = w << k;
    ee = int'(e) - k;
    sig = {1'b0, wn[25:2]} + 25'(wn[1]);
    if (sig == 25'h1000000) ee++;
    res = (ee >= 255) ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'(ee), sig[22:0]};
    lat = k + 2;
  endfunction
  task automatic run(input logic [24:0] m, input logic r, input logic [7:0] e, input logic s,
                     input logic [31:0] xr, input logic xz, input logic xu, input int xl,
                     input int hold);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.m_r = m;
    bus.round_in = r;
    bus.exp_in = e;
    bus.sign_in = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    chk("latency", 32'(lat), 32'(xl));
    chk("result", bus.result, xr);
    chk("zero", 32'(bus.zero), 32'(xz));
    chk("underflow", 32'(bus.underflow), 32'(xu));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.m_r = 25'($urandom);
      bus.exp_in = 8'($urandom_range(1, 254));
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("hold_result", bus.result, xr);
      chk("hold_valid", {bus.out_valid, bus.in_ready, bus.zero, bus.underflow},
          {1'b1, 1'b0, xz, xu});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release", {bus.out_valid, bus.in_ready}, 32'b01);
  endtask
  initial begin
    logic [31:0] xr;
    logic xz, xu;
    int xl;
    logic [24:0] mm;
    logic rr, ss;
    logic [7:0] ee;
    vecs[0] = '{25'h1000000, 1'b0, 8'h80, 1'b0, 32'h40000000, 1'b0, 1'b0, 2, 0};
    vecs[1] = '{25'h0400000, 1'b0, 8'h80, 1'b0, 32'h3F000000, 1'b0, 1'b0, 4, 0};
    vecs[2] = '{25'h0000000, 1'b0, 8'h80, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{25'h1FFFFFF, 1'b0, 8'h7F, 1'b0, 32'h40000000, 1'b0, 1'b0, 2, 0};
    vecs[4] = '{25'h0000100, 1'b0, 8'h03, 1'b1, 32'h80000000, 1'b0, 1'b1, 3, 0};
    vecs[5] = '{25'h1000000, 1'b0, 8'h80, 1'b0, 32'h40000000, 1'b0, 1'b0, 2, 5};
    vecs[6] = '{25'h0800000, 1'b0, 8'h01, 1'b0, 32'h00000000, 1'b0, 1'b1, 1, 0};
    vecs[7] = '{25'h0000000, 1'b1, 8'h1E, 1'b1, 32'h82800000, 1'b0, 1'b0, 27, 0};
    vecs[8] = '{25'h1000001, 1'b0, 8'h80, 1'b0, 32'h40000001, 1'b0, 1'b0, 2, 0};
    vecs[9] = '{25'h0400000, 1'b0, 8'h80, 1'b1, 32'hBF000000, 1'b0, 1'b0, 4, 1};
    bus.in_valid = 1'b0;
    bus.m_r = '0;
    bus.round_in = 1'b0;
    bus.exp_in = '0;
    bus.sign_in = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.in_ready, bus.out_valid, bus.zero, bus.underflow}, 32'b1000);
    chk("reset_result", bus.result, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++)
      run(vecs[i].m, vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].res, vecs[i].z, vecs[i].u,
          vecs[i].lat, vecs[i].hold);
    @(negedge clk);
    bus.m_r = 25'h0000100;
    bus.round_in = 1'b0;
    bus.exp_in = 8'h80;
    bus.sign_in = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_state", {bus.out_valid, bus.in_ready}, 32'b01);
    chk("abort_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_quiet", {bus.out_valid, bus.in_ready}, 32'b01);
    run(25'h1000000, 1'b0, 8'h80, 1'b0, 32'h40000000, 1'b0, 1'b0, 2, 0);
    for (int n = 0; n < 200; n++) begin
      mm = 25'($urandom) >> $urandom_range(0, 25);
      rr = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        mm = '0;
        rr = 1'b0;
      end
      ee = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 3) == 0) ee = 8'($urandom_range(1, 28));
      ss = 1'($urandom);
      model(mm, rr, ee, ss, xr, xz, xu, xl);
      run(mm, rr, ee, ss, xr, xz, xu, xl, $urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
